// File: rtl/csla_pkg.sv
// csla_pkg: shared definitions for the nibble-serial carry-select add/subtract unit.
//   NIBBLE     - slice width in bits
//   OP_ADD/SUB - encodings of the Sub control input
//   state_t    - controller states
//   nib_res_t  - result bundle of one 4-bit ripple adder
//   ripple4()  - 4-bit ripple-carry add with a fixed carry-in, also exposing
//                the carry into bit 3 for signed-overflow detection

package csla_pkg;

    localparam int NIBBLE = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] s;
        logic       co;
        logic       c3;
    } nib_res_t;

    function automatic nib_res_t ripple4(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci);
        nib_res_t   r;
        logic [4:0] c;
        c[0] = ci;
        r.s  = 4'b0;
        for (int i = 0; i < 4; i++) begin
            r.s[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        r.co = c[4];
        r.c3 = c[3];
        return r;
    endfunction

endpackage

// File: rtl/csla_nibble.sv
// csla_nibble: combinational 4-bit carry-select slice.
// Two ripple adders evaluate the slice for carry-in 0 and 1 in parallel; the
// real carry-in only drives the final select mux.
//   a, b  in  4  slice operands
//   c     in  1  carry-in (select)
//   s     out 4  slice sum
//   co    out 1  carry out of bit 3
//   c3    out 1  carry into bit 3 (MSB of the slice), used for overflow

module csla_nibble
    import csla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    nib_res_t res0;
    nib_res_t res1;

    assign res0 = ripple4(a, b, 1'b0);
    assign res1 = ripple4(a, b, 1'b1);

    assign s  = c ? res1.s  : res0.s;
    assign co = c ? res1.co : res0.co;
    assign c3 = c ? res1.c3 : res0.c3;

endmodule

// File: rtl/csla_seq_addsub.sv
// csla_seq_addsub: nibble-serial add/subtract unit, one 4-bit slice per clock, LSB first.
// Subtraction is A + ~B + ~Cin, so Cin acts as borrow-in and Cout reports borrow-out.
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, honoured in IDLE or DONE, ignored while busy
//   Sub    in   1      0: A+B+Cin, 1: A-B-Cin
//   A, B   in   WIDTH  operands (sampled only on the accept edge)
//   Cin    in   1      carry-in / borrow-in
//   busy   out  1      high while nibbles are being processed
//   done   out  1      one-cycle pulse when S/Cout/V become valid
//   S      out  WIDTH  sum or difference
//   Cout   out  1      carry-out (add) or borrow-out (sub)
//   V      out  1      two's-complement overflow

module csla_seq_addsub
    import csla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int N     = WIDTH / NIBBLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted for subtraction
    logic             sub_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] nib_s;
    logic       nib_co;
    logic       nib_c3;

    assign a_nib = a_q[int'(cnt_q) * NIBBLE +: NIBBLE];
    assign b_nib = b_q[int'(cnt_q) * NIBBLE +: NIBBLE];

    csla_nibble u_nibble (
        .a  (a_nib),
        .b  (b_nib),
        .c  (carry_q),
        .s  (nib_s),
        .co (nib_co),
        .c3 (nib_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= '0;
            Cout    <= 1'b0;
            V       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= (Sub == OP_SUB) ? ~B : B;
                        sub_q   <= Sub;
                        // Subtract as A + ~B + 1 - borrow_in.
                        carry_q <= (Sub == OP_ADD) ? Cin : ~Cin;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    S[int'(cnt_q) * NIBBLE +: NIBBLE] <= nib_s;
                    carry_q <= nib_co;
                    if (cnt_q == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Final carry is inverted into a borrow for subtraction.
                        Cout  <= nib_co ^ sub_q;
                        V     <= nib_c3 ^ nib_co;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csla_seq_addsub.sv
module tb_csla_seq_addsub;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        poke  = 1'b0;
    logic        Sub   = 1'b0;
    logic        Cin   = 1'b0;
    logic [15:0] A     = '0;
    logic [15:0] B     = '0;

    logic        busy4, done4, cout4, v4;
    logic [3:0]  s4;
    logic        busy8, done8, cout8, v8;
    logic [7:0]  s8;
    logic        busy16, done16, cout16, v16;
    logic [15:0] s16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csla_seq_addsub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .Sub(Sub), .A(A[3:0]), .B(B[3:0]),
        .Cin(Cin), .busy(busy4), .done(done4), .S(s4), .Cout(cout4), .V(v4)
    );

    // The wider units also see stray start pulses issued while they are running.
    csla_seq_addsub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start | poke), .Sub(Sub), .A(A[7:0]), .B(B[7:0]),
        .Cin(Cin), .busy(busy8), .done(done8), .S(s8), .Cout(cout8), .V(v8)
    );

    csla_seq_addsub #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start | poke), .Sub(Sub), .A(A), .B(B),
        .Cin(Cin), .busy(busy16), .done(done16), .S(s16), .Cout(cout16), .V(v16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the w-bit operands.
    task automatic model(input int w, input logic sub, input logic cin,
                         input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] s, output logic c, output logic v);
        longint m, half, aa, bb, full, sa, sb, r, ci;
        m    = (64'sd1 <<< w) - 1;
        half = 64'sd1 <<< (w - 1);
        aa   = longint'(a) & m;
        bb   = longint'(b) & m;
        ci   = cin ? 64'sd1 : 64'sd0;
        full = sub ? (aa - bb - ci) : (aa + bb + ci);
        s    = 16'(full & m);
        c    = sub ? (full < 0) : (full > m);
        sa   = (aa >= half) ? aa - 2 * half : aa;
        sb   = (bb >= half) ? bb - 2 * half : bb;
        r    = sub ? (sa - sb - ci) : (sa + sb + ci);
        v    = (r < -half) || (r > half - 1);
    endtask

    task automatic check_res(input int w, input logic sub, input logic cin,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] s_got, input logic c_got, input logic v_got);
        logic [15:0] es;
        logic        ec, ev;
        model(w, sub, cin, a, b, es, ec, ev);
        check($sformatf("S w%0d %0h%s%0h", w, a, sub ? "-" : "+", b), 32'(s_got), 32'(es));
        check($sformatf("Cout w%0d", w), 32'(c_got), 32'(ec));
        check($sformatf("V w%0d", w), 32'(v_got), 32'(ev));
    endtask

    // Issue one operation to all three units, track done latency, then check results.
    task automatic do_op(input logic sub, input logic cin, input logic [15:0] a,
                         input logic [15:0] b, input bit poke_run);
        int d4, d8, d16;
        d4 = 0; d8 = 0; d16 = 0;
        @(negedge clk);
        Sub = sub; Cin = cin; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); Sub = 1'($urandom); Cin = 1'($urandom);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done4  && d4  == 0) d4  = k;
            if (done8  && d8  == 0) d8  = k;
            if (done16 && d16 == 0) d16 = k;
            if (k == 1) check("busy16 after accept", 32'(busy16), 32'd1);
            if (k == 5) begin
                check("done16 one cycle", 32'(done16), 32'd0);
                check("busy16 idle", 32'(busy16), 32'd0);
            end
            poke = (k == 1) && poke_run;
            if (poke) begin
                A = 16'($urandom); B = 16'($urandom);
            end
        end
        poke = 1'b0;
        check("latency w4", 32'(d4), 32'd1);
        check("latency w8", 32'(d8), 32'd2);
        check("latency w16", 32'(d16), 32'd4);
        check_res(4,  sub, cin, a, b, {12'b0, s4}, cout4, v4);
        check_res(8,  sub, cin, a, b, {8'b0, s8},  cout8, v8);
        check_res(16, sub, cin, a, b, s16,         cout16, v16);
    endtask

    initial begin
        logic [15:0] es;
        logic        ec, ev;

        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy16), 32'd0);
        check("rst done", 32'(done16), 32'd0);
        check("rst S", 32'(s16), 32'd0);
        check("rst Cout", 32'(cout16), 32'd0);
        check("rst V", 32'(v16), 32'd0);
        rst_n = 1'b1;

        do_op(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
        do_op(1'b1, 1'b0, 16'h1234, 16'h0235, 1'b0);
        do_op(1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0);
        do_op(1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        do_op(1'b1, 1'b0, 16'h8000, 16'h0001, 1'b1);
        do_op(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1);

        // Back-to-back: start asserted during DONE.
        @(negedge clk);
        Sub = 1'b0; Cin = 1'b0; A = 16'h1111; B = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b done1", 32'(done16), 32'd1);
        Sub = 1'b1; Cin = 1'b1; A = 16'h0F0F; B = 16'h00F1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy", 32'(busy16), 32'd1);
        check("b2b done low", 32'(done16), 32'd0);
        check("b2b S held", 32'(s16), 32'h3333);
        A = 16'($urandom); B = 16'($urandom);
        repeat (4) @(negedge clk);
        check("b2b done2", 32'(done16), 32'd1);
        check_res(16, 1'b1, 1'b1, 16'h0F0F, 16'h00F1, s16, cout16, v16);

        // Asynchronous reset during nibble 2.
        @(negedge clk);
        Sub = 1'b0; Cin = 1'b0; A = 16'h1234; B = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-rst busy", 32'(busy16), 32'd1);
        check("pre-rst low byte", 32'(s16[7:0]), 32'h45);
        #2 rst_n = 1'b0;
        #1;
        check("async S", 32'(s16), 32'd0);
        check("async Cout", 32'(cout16), 32'd0);
        check("async V", 32'(v16), 32'd0);
        check("async busy", 32'(busy16), 32'd0);
        check("async done", 32'(done16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 1'b0, 16'h0001, 16'h0002, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom));
        end

        // Model sanity against a hand value the unit must also reproduce.
        model(16, 1'b1, 1'b0, 16'h8000, 16'h0001, es, ec, ev);
        check("model ovf sub", {15'b0, ev, es}, {15'b0, 1'b1, 16'h7FFF});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
